// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction fetch front end: issues sequential fetch requests to the icache,
// enqueues returned words (32-bit or RVC) into a small circular queue and
// presents the oldest entry to the decoder. Fetch optionally halts after a
// control-flow instruction until the decoder supplies a redirect target.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   rdy                    global enable; low freezes all state
//   flush, flush_pc        pipeline flush and restart PC
//   redirect, redirect_pc  decoder-resolved target, honoured only while halted
//   req_valid, req_pc      fetch request to the icache
//   rsp_valid, rsp_inst    icache response for req_pc
//   out_valid, out_ready   queue head handshake with the decoder
//   out_pc, out_inst       head entry PC and raw word
//   out_is_rv32            head entry is a 32-bit instruction (1) or RVC (0)
//   out_count              number of occupied queue entries
module fetch_queue #(
   parameter int unsigned DEPTH         = 4,
   parameter logic [31:0] RESET_PC      = 32'h0,
   parameter bit          STALL_ON_CTRL = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     flush,
   input  logic [31:0]              flush_pc,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     req_valid,
   output logic [31:0]              req_pc,
   input  logic                     rsp_valid,
   input  logic [31:0]              rsp_inst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_inst,
   output logic                     out_is_rv32,
   output logic [$clog2(DEPTH):0]   out_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_HALT  = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   w_pc_nxt;
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic [AW:0]   w_count_nxt;

   logic [31:0]   r_q_pc   [DEPTH];
   logic [31:0]   r_q_inst [DEPTH];
   logic          r_q_rv32 [DEPTH];

   logic          w_enq;
   logic          w_deq;
   logic          w_is_rv32;
   logic          w_is_ctrl;

   // Control-flow decode: JAL/JALR/branches, C.JAL/C.J/C.BEQZ/C.BNEZ,
   // and the quadrant-2 jump-register group (rs2 field zero).
   function automatic logic f_is_ctrl(input logic [31:0] inst);
      logic v_ctrl;
      v_ctrl = 1'b0;
      case (inst[1:0])
         2'b11: begin
            case (inst[6:0])
               7'b1101111: v_ctrl = 1'b1;
               7'b1100111: v_ctrl = 1'b1;
               7'b1100011: v_ctrl = 1'b1;
               default:    v_ctrl = 1'b0;
            endcase
         end
         2'b01: begin
            case (inst[15:13])
               3'b001:  v_ctrl = 1'b1;
               3'b101:  v_ctrl = 1'b1;
               3'b110:  v_ctrl = 1'b1;
               3'b111:  v_ctrl = 1'b1;
               default: v_ctrl = 1'b0;
            endcase
         end
         2'b10: begin
            v_ctrl = (inst[15:13] == 3'b100) && (inst[6:2] == 5'd0);
         end
         default: v_ctrl = 1'b0;
      endcase
      return v_ctrl;
   endfunction

   // Request, head presentation and handshake qualifiers.
   always_comb begin
      req_valid   = ~rst & rdy & (r_state == ST_FETCH) & (r_count < CNT_FULL) & ~flush;
      req_pc      = r_pc;
      out_valid   = ~rst & (r_count != {(AW+1){1'b0}});
      out_pc      = r_q_pc[r_head];
      out_inst    = r_q_inst[r_head];
      out_is_rv32 = r_q_rv32[r_head];
      out_count   = r_count;
      // zero words are treated as "no instruction" and dropped
      w_enq       = req_valid & rsp_valid & (rsp_inst != 32'h0);
      w_deq       = rdy & ~flush & out_valid & out_ready;
      w_is_rv32   = (rsp_inst[1:0] == 2'b11);
      w_is_ctrl   = f_is_ctrl(rsp_inst);
   end

   // Next-state, next-PC and occupancy; flush takes priority over everything.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_count_nxt = r_count;
      if (flush) begin
         w_state_nxt = ST_FETCH;
         w_pc_nxt    = flush_pc;
         w_count_nxt = {(AW+1){1'b0}};
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_enq) begin
                  w_pc_nxt = r_pc + (w_is_rv32 ? 32'd4 : 32'd2);
                  if (STALL_ON_CTRL && w_is_ctrl) begin
                     w_state_nxt = ST_HALT;
                  end else begin
                     w_state_nxt = ST_FETCH;
                  end
               end else begin
                  w_pc_nxt = r_pc;
               end
            end
            ST_HALT: begin
               if (redirect) begin
                  w_state_nxt = ST_FETCH;
                  w_pc_nxt    = redirect_pc;
               end else begin
                  w_state_nxt = ST_HALT;
               end
            end
            default: begin
               w_state_nxt = ST_FETCH;
            end
         endcase
         case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Control registers: state, PC, pointers and count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC;
         r_head  <= {AW{1'b0}};
         r_tail  <= {AW{1'b0}};
         r_count <= {(AW+1){1'b0}};
      end else if (rdy) begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_count <= w_count_nxt;
         if (flush) begin
            r_head <= {AW{1'b0}};
            r_tail <= {AW{1'b0}};
         end else begin
            // pointers wrap naturally since DEPTH is a power of two
            if (w_enq) r_tail <= r_tail + PTR_ONE;
            if (w_deq) r_head <= r_head + PTR_ONE;
         end
      end
   end

   // Queue storage; contents of free slots are never observed.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_q_pc[r_tail]   <= r_pc;
         r_q_inst[r_tail] <= rsp_inst;
         r_q_rv32[r_tail] <= w_is_rv32;
      end
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, fetch PC after reset.
REQ-003 SHALL have parameter STALL_ON_CTRL, default 1, where 1 halts fetch after a control-flow instruction and 0 keeps fetching sequentially.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port rdy  in  1  global enable; low freezes all state.
REQ-007 SHALL have port flush  in  1  ROB misprediction/exception flush.
REQ-008 SHALL have port flush_pc  in  32  restart PC on flush.
REQ-009 SHALL have port redirect  in  1  decoder-resolved control-flow target valid.
REQ-010 SHALL have port redirect_pc  in  32  decoder target PC.
REQ-011 SHALL have port req_valid  out  1  fetch request to icache.
REQ-012 SHALL have port req_pc  out  32  address of requested instruction.
REQ-013 SHALL have port rsp_valid  in  1  icache data valid for req_pc.
REQ-014 SHALL have port rsp_inst  in  32  raw fetched word (low 16 bits hold a compressed instruction).
REQ-015 SHALL have port out_valid  out  1  queue head valid.
REQ-016 SHALL have port out_ready  in  1  decoder consumes head.
REQ-017 SHALL have port out_pc, out_inst  out  32 each  head PC and raw word.
REQ-018 SHALL have port out_is_rv32  out  1  head is a 32-bit instruction (1) or RVC (0).
REQ-019 SHALL have port out_count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-020 SHALL implement FSM states FETCH and HALT; HALT only reachable when STALL_ON_CTRL=1.
REQ-021 SHALL drive req_valid = rdy & state==FETCH & count<DEPTH & !flush, and req_pc = fetch PC register, combinationally.
REQ-022 SHALL accept a response only when req_valid & rsp_valid & rsp_inst!=0; an accepted response enqueues {req_pc, rsp_inst, is_rv32} at tail in the same edge.
REQ-023 SHALL discard rsp_inst==32'h0 responses, leaving PC, queue and state unchanged.
REQ-024 SHALL set is_rv32 = (rsp_inst[1:0]==2'b11), and on accept advance PC by 4 if is_rv32, else by 2, with 32-bit wrap-around.
REQ-025 SHALL classify as control-flow: 32-bit opcodes 1101111, 1100111, 1100011; RVC quadrant 01 funct3 001/101/110/111; RVC quadrant 10 funct3 100 with inst[6:2]==0.
REQ-026 SHALL move FETCH->HALT on accepting a control-flow instruction when STALL_ON_CTRL=1.
REQ-027 SHALL, in HALT with redirect=1 and flush=0, load PC<=redirect_pc, enter FETCH and keep queue contents; redirect SHALL be ignored in FETCH.
REQ-028 SHALL, on flush=1 (rdy high), empty the queue, load PC<=flush_pc, enter FETCH and accept no response that edge; flush wins over redirect, enqueue and dequeue.
REQ-029 SHALL present head entry on out_* combinationally, with out_valid = count!=0; dequeue occurs when out_valid & out_ready.
REQ-030 SHALL allow enqueue and dequeue in the same edge, count unchanged; when full no enqueue occurs (req_valid low) but dequeue proceeds.
REQ-031 SHALL wrap head/tail pointers modulo DEPTH.
REQ-032 SHALL keep out_* values of an empty queue don't-care, and out_valid low.

Reset
REQ-033 SHALL on rst=1 (regardless of rdy) set PC=RESET_PC, state=FETCH, head=tail=count=0, out_valid=0, req_valid=0 that cycle.
REQ-034 SHALL abort any in-flight request on reset; a rsp_valid in the reset cycle is ignored.

Verification
REQ-035 SHALL verify sequential mix: responses 0x00500093 (addi), 0x4505 (c.li), 0x00a00113 from PC 0 -> out_pc 0, 4, 6 with out_is_rv32 1, 0, 1.
REQ-036 SHALL verify stall: STALL_ON_CTRL=1, 0x0080006f (jal) at PC 8 -> req_valid low after it; redirect_pc 0x10 -> next req_pc 0x10, queue intact.
REQ-037 SHALL verify full queue: DEPTH=4, out_ready=0, 5 valid responses -> out_count 4, req_valid 0; one dequeue -> fifth fetch accepted, head order preserved.
REQ-038 SHALL verify flush priority: flush=1, flush_pc 0x100, redirect=1 and rsp_valid=1 in the same cycle -> out_count 0, req_pc 0x100, FETCH.
REQ-039 SHALL verify rdy=0 for 3 cycles with rsp_valid=1 -> no state change; zero-word response -> discarded, same req_pc repeated.
REQ-040 SHALL verify STALL_ON_CTRL=0: branch 0xfe000ee3 at PC 0x20 -> next req_pc 0x24 without HALT.
